// File: rtl/pd_pkg.sv
// Shared definitions for the pd pipeline: RV32I opcodes, immediate classes
// and the per-entry decoded record carried by the decode stage.
package pd_pkg;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_FENCE  = 7'h0F;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_state_e;

    typedef struct packed {
        logic [31:0] insn;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } decoded_t;

    // Legal base opcodes that carry no immediate field.
    function automatic logic is_immless_op(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_FENCE);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: classifies the instruction format
// from its opcode and assembles the sign-extended immediate.
module imm_gen
    import pd_pkg::*;
(
    input  logic [31:0] insn,
    output logic [31:0] imm,
    output imm_type_e   imm_type
);

    always_comb begin
        imm_type = IMM_NONE;
        case (insn[6:0])
            OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: imm_type = IMM_I;
            OP_STORE:                            imm_type = IMM_S;
            OP_BRANCH:                           imm_type = IMM_B;
            OP_LUI, OP_AUIPC:                    imm_type = IMM_U;
            OP_JAL:                              imm_type = IMM_J;
            default:                             imm_type = IMM_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{20{insn[31]}}, insn[31:20]};
            IMM_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B: imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
            IMM_U: imm = {insn[31:12], 12'b0};
            IMM_J: imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: splits the accepted word into fields and holds results
// in a main/skid pair so ready_o depends only on registered occupancy.
module decode
    import pd_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [DWIDTH-1:0] imm_o,
    output logic              illegal_o
);

    occ_state_e        state;
    occ_state_e        state_next;
    decoded_t          incoming;
    decoded_t          main_q;
    decoded_t          skid_q;
    logic [AWIDTH-1:0] pc_main_q;
    logic [AWIDTH-1:0] pc_skid_q;
    logic [31:0]       insn_w;
    logic [31:0]       imm_w;
    imm_type_e         imm_type_w;
    logic              accept;
    logic              pop;
    logic              load_main;
    logic              load_skid;
    logic              shift_skid;

    assign insn_w  = insn_i;
    assign ready_o = (state != OCC_TWO);
    assign valid_o = (state != OCC_EMPTY);
    assign accept  = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    imm_gen u_imm_gen (
        .insn     (insn_w),
        .imm      (imm_w),
        .imm_type (imm_type_w)
    );

    always_comb begin
        incoming         = '0;
        incoming.insn    = insn_w;
        incoming.opcode  = insn_w[6:0];
        incoming.rd      = insn_w[11:7];
        incoming.rs1     = insn_w[19:15];
        incoming.rs2     = insn_w[24:20];
        incoming.funct3  = insn_w[14:12];
        incoming.funct7  = insn_w[31:25];
        incoming.imm     = imm_w;
        incoming.illegal = (imm_type_w == IMM_NONE) && !is_immless_op(insn_w[6:0]);
    end

    // Occupancy transitions; flush overrides any accept or pop in the same cycle.
    always_comb begin
        state_next = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (state)
            OCC_EMPTY: begin
                if (accept) begin
                    state_next = OCC_ONE;
                    load_main  = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_next = OCC_TWO;
                    load_skid  = 1'b1;
                end else if (pop) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    state_next = OCC_ONE;
                    shift_skid = 1'b1;
                end
            end
            default: state_next = OCC_EMPTY;
        endcase
        if (flush_i) begin
            state_next = OCC_EMPTY;
            load_main  = 1'b0;
            load_skid  = 1'b0;
            shift_skid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q    <= '0;
            skid_q    <= '0;
            pc_main_q <= '0;
            pc_skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q    <= incoming;
                pc_main_q <= pc_i;
            end else if (shift_skid) begin
                main_q    <= skid_q;
                pc_main_q <= pc_skid_q;
            end
            if (load_skid) begin
                skid_q    <= incoming;
                pc_skid_q <= pc_i;
            end
        end
    end

    assign pc_o      = pc_main_q;
    assign insn_o    = main_q.insn;
    assign opcode_o  = main_q.opcode;
    assign rd_o      = main_q.rd;
    assign rs1_o     = main_q.rs1;
    assign rs2_o     = main_q.rs2;
    assign funct3_o  = main_q.funct3;
    assign funct7_o  = main_q.funct7;
    assign imm_o     = main_q.imm;
    assign illegal_o = main_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: the stimulus side pushes reference-model
// results, an independent monitor pops and compares what the stage presents.
module tb_decode;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic [31:0] insn_i;
    logic        valid_i;
    logic        ready_o;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [2:0]  funct3_o;
    logic [6:0]  funct7_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] imm;
        logic        illegal;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [6:0]  legal_ops[11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                   7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    decode #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_i      (pc_i),
        .insn_i    (insn_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pc_o      (pc_o),
        .insn_o    (insn_o),
        .opcode_o  (opcode_o),
        .rd_o      (rd_o),
        .rs1_o     (rs1_o),
        .rs2_o     (rs2_o),
        .funct3_o  (funct3_o),
        .funct7_o  (funct7_o),
        .imm_o     (imm_o),
        .illegal_o (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Immediate computed arithmetically from bit weights rather than by concatenation.
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int s;
        int v;
        s = int'(w);
        v = 0;
        case (w & 32'h7F)
            32'h03, 32'h13, 32'h67, 32'h73: v = s >>> 20;
            32'h23: v = ((s >>> 25) * 32) + int'((w >> 7) & 32'h1F);
            32'h63: v = (w[31] ? -4096 : 0) + int'((w >> 7) & 1) * 2048
                        + int'((w >> 25) & 32'h3F) * 32 + int'((w >> 8) & 32'hF) * 2;
            32'h37, 32'h17: v = int'(w & 32'hFFFFF000);
            32'h6F: v = (w[31] ? -(1 << 20) : 0) + int'((w >> 12) & 32'hFF) * 4096
                        + int'((w >> 20) & 1) * 2048 + int'((w >> 21) & 32'h3FF) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic ref_illegal(input logic [31:0] w);
        for (int i = 0; i < 11; i++) begin
            if ((w & 32'h7F) == {25'd0, legal_ops[i]}) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: occupancy-derived handshake checks and in-order field comparison.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                check_output("valid_o", {31'd0, valid_o}, {31'd0, sb.size() != 0});
                check_output("ready_o", {31'd0, ready_o}, {31'd0, sb.size() < 2});
                if (valid_o && ready_i) begin
                    if (sb.size() == 0) begin
                        check_output("pop_empty", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check_output("pc_o",      pc_o,                 e.pc);
                        check_output("insn_o",    insn_o,               e.insn);
                        check_output("opcode_o",  {25'd0, opcode_o},    e.insn & 32'h7F);
                        check_output("rd_o",      {27'd0, rd_o},        (e.insn >> 7) & 32'h1F);
                        check_output("rs1_o",     {27'd0, rs1_o},       (e.insn >> 15) & 32'h1F);
                        check_output("rs2_o",     {27'd0, rs2_o},       (e.insn >> 20) & 32'h1F);
                        check_output("funct3_o",  {29'd0, funct3_o},    (e.insn >> 12) & 32'h7);
                        check_output("funct7_o",  {25'd0, funct7_o},    e.insn >> 25);
                        check_output("imm_o",     imm_o,                e.imm);
                        check_output("illegal_o", {31'd0, illegal_o},   {31'd0, e.illegal});
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input bit v, input logic [31:0] pc, input logic [31:0] w,
                                  input bit rdy, input bit fl, output bit accepted);
        exp_t e;
        @(negedge clk);
        valid_i = v;
        pc_i    = pc;
        insn_i  = w;
        ready_i = rdy;
        flush_i = fl;
        #2;
        accepted = valid_i && ready_o && rst && !flush_i;
        if (flush_i) begin
            sb.delete();
        end else if (accepted) begin
            e.pc      = pc;
            e.insn    = w;
            e.imm     = ref_imm(w);
            e.illegal = ref_illegal(w);
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] w, input bit rdy);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            apply_stimulus(1'b1, pc, w, rdy, 1'b0, acc);
            n++;
        end
        if (!acc) check_output("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
            n++;
        end
        apply_stimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
        if (sb.size() != 0) check_output("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_valid_o",   {31'd0, valid_o},   32'd0);
        check_output("rst_ready_o",   {31'd0, ready_o},   32'd1);
        check_output("rst_pc_o",      pc_o,               32'd0);
        check_output("rst_insn_o",    insn_o,             32'd0);
        check_output("rst_opcode_o",  {25'd0, opcode_o},  32'd0);
        check_output("rst_imm_o",     imm_o,              32'd0);
        check_output("rst_illegal_o", {31'd0, illegal_o}, 32'd0);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(3) != 0) w = (w & ~32'h7F) | {25'd0, legal_ops[$urandom_range(10)]};
        return w;
    endfunction

    initial begin
        bit acc;
        rst     = 1'b0;
        valid_i = 1'b0;
        pc_i    = '0;
        insn_i  = '0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check_reset_outputs();
        rst = 1'b1;

        // Single addi, then a back-to-back stream.
        send(32'h0100_0000, 32'hFFB1_0093, 1'b1);
        send(32'h0100_0004, 32'h0053_2423, 1'b1);
        send(32'h0100_0008, 32'h1234_51B7, 1'b1);
        send(32'h0100_000C, 32'hFFDF_F06F, 1'b1);
        drain();

        // Backpressure: three words offered while downstream stalls.
        send(32'h0000_0100, 32'h0010_0113, 1'b0);
        send(32'h0000_0104, 32'h0020_0193, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0108, 32'h0030_0213, 1'b0, 1'b0, acc);
        check_output("third_held", {31'd0, acc}, 32'd0);
        apply_stimulus(1'b1, 32'h0000_0108, 32'h0030_0213, 1'b0, 1'b0, acc);
        send(32'h0000_0108, 32'h0030_0213, 1'b1);
        drain();

        // All-zero word is illegal but still flows.
        send(32'h0000_0200, 32'h0000_0000, 1'b1);
        drain();

        // Flush while full with a word offered.
        send(32'h0000_0300, 32'h0000_0033, 1'b0);
        send(32'h0000_0304, 32'h0000_0037, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0308, 32'h0000_0013, 1'b0, 1'b1, acc);
        drain();

        // Asynchronous reset while full.
        send(32'h0000_0400, 32'h0040_0293, 1'b0);
        send(32'h0000_0404, 32'h0050_0313, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        #3;
        rst = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs();
        @(negedge clk);
        #3;
        rst = 1'b1;
        send(32'h0000_0500, 32'hFFB1_0093, 1'b1);
        drain();

        // Randomized traffic with random backpressure and occasional flush.
        for (int i = 0; i < 3000; i++) begin
            apply_stimulus($urandom_range(9) < 7, $urandom & 32'hFFFF_FFFC, rand_insn(),
                           $urandom_range(9) < 6, $urandom_range(39) == 0, acc);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
